// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue path:
//   - ALU_WIDTH     : operand width carried by alu_op_t
//   - ALU_SEL_*     : select codes understood by the arithmetic unit
//   - alu_op_t      : one queued operation {a, b, select}
//   - is_legal_sel  : true for the select codes the arithmetic unit supports
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_SEL_ADD = 4'b0000;
    localparam logic [3:0] ALU_SEL_SUB = 4'b0010;
    localparam logic [3:0] ALU_SEL_SLT = 4'b1010;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        logic [3:0]           select;
    } alu_op_t;

    function automatic logic is_legal_sel(input logic [3:0] sel);
        return (sel == ALU_SEL_ADD) || (sel == ALU_SEL_SUB) || (sel == ALU_SEL_SLT);
    endfunction

endpackage

// File: rtl/alu_issue_fifo_if.sv
// -----------------------------------------------------------------------------
// alu_issue_fifo_if
// Bundles the producer-side push handshake and the consumer-side head outputs
// of alu_issue_fifo.
//   slave  : the FIFO itself (takes in_*, out_ready; drives in_ready, out_*,
//            count, err_illegal)
//   master : the environment (decode producer plus arithmetic-unit consumer)
// Parameters: WIDTH operand width, DEPTH FIFO entries (sizes count).
// -----------------------------------------------------------------------------
interface alu_issue_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_select;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [3:0]       out_select;

    logic [CW-1:0]    count;
    logic             err_illegal;

    modport slave (
        input  in_valid, in_a, in_b, in_select, out_ready,
        output in_ready, out_valid, out_a, out_b, out_select, count, err_illegal
    );

    modport master (
        output in_valid, in_a, in_b, in_select, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_select, count, err_illegal
    );

endinterface

// File: rtl/alu_fifo_mem.sv
// -----------------------------------------------------------------------------
// alu_fifo_mem
// DEPTH x alu_op_t register file for the issue FIFO.
//   clk, reset : clock and synchronous active-high clear of every entry
//   wr_en      : write wr_data into entry wr_addr on the rising edge
//   rd_addr    : read address; rd_data is a combinational mux of the flops
// Kept as flops (not block RAM) so the head is visible without a read cycle.
// -----------------------------------------------------------------------------
module alu_fifo_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  alu_op_t       wr_data,
    input  logic [AW-1:0] rd_addr,
    output alu_op_t       rd_data
);

    alu_op_t mem_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/alu_issue_fifo.sv
// -----------------------------------------------------------------------------
// alu_issue_fifo
// In-order issue buffer between decode and the 32-bit arithmetic unit.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (clears pointers, count, storage)
//   bus   : alu_issue_fifo_if.slave
//           in_valid/in_ready/in_a/in_b/in_select  push side
//           out_valid/out_ready/out_a/out_b/out_select  head to arithmetic unit
//           count        occupancy, $clog2(DEPTH)+1 bits
//           err_illegal  one-cycle pulse per dropped illegal op
// Optional build macro: ALU_ISSUE_ILLEGAL_CHECK_EN
//   defined   : pushes with a select other than ADD/SUB/SLT complete the
//               handshake but are discarded, and err_illegal pulses
//   undefined : every select is stored; err_illegal is tied 0
// DEPTH must be a power of two >= 2; WIDTH must equal alu_pkg::ALU_WIDTH.
// -----------------------------------------------------------------------------
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_fifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic          err_reg,    err_next;

    logic          push_fire;
    logic          pop_fire;
    logic          wr_en;
    alu_op_t       wr_data;
    alu_op_t       head;

    // Readiness only looks at occupancy, so a pop never frees a slot for a
    // push in the same cycle and there is no out_ready -> in_ready path.
    assign bus.in_ready  = (count_reg != CW'(DEPTH));
    assign bus.out_valid = (count_reg != '0);

    assign push_fire = bus.in_valid && bus.in_ready;
    assign pop_fire  = bus.out_valid && bus.out_ready;

    assign wr_data.a      = bus.in_a;
    assign wr_data.b      = bus.in_b;
    assign wr_data.select = bus.in_select;

`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    logic sel_legal;
    assign sel_legal = is_legal_sel(bus.in_select);
    assign wr_en     = push_fire && sel_legal;
    assign err_next  = push_fire && !sel_legal;
`else
    assign wr_en     = push_fire;
    assign err_next  = 1'b0;
`endif

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        // Pointers are exactly AW bits, so +1 wraps DEPTH-1 -> 0 on its own.
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop_fire) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({wr_en, pop_fire})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
        end
    end

    alu_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (head)
    );

    assign bus.out_a       = head.a;
    assign bus.out_b       = head.b;
    assign bus.out_select  = head.select;
    assign bus.count       = count_reg;
    assign bus.err_illegal = err_reg;

endmodule
